// File: rtl/abuf_acc_pkg.sv
// Shared project parameters used by the accumulation buffer and its bench.
// Holds the lane count and a width helper; there is no logic here.
// Neither latency nor backpressure applies.
package global_param;

  // Number of parallel MAC lanes per buffer word.
  localparam int BATCH = 4;

  // Minimum number of bits needed to index n items (at least 1).
  function automatic int bw(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/abuf_acc_sdp_ram.sv
// Simple dual-port RAM: one write port and one registered read port.
// Latency: read data appears 1 cycle after raddr. On a same-address collision it returns the old word.
// Backpressure: none. Contents are not reset.
//   clk          : single clock
//   we/waddr/wdata : write port
//   raddr/rdata  : read port
module sdp_ram #(
  parameter int DEPTH_W = 8,
  parameter int DW      = 16
) (
  input  logic               clk,
  input  logic               we,
  input  logic [DEPTH_W-1:0] waddr,
  input  logic [DW-1:0]      wdata,
  input  logic [DEPTH_W-1:0] raddr,
  output logic [DW-1:0]      rdata
);

  logic [DW-1:0] mem [0:(1<<DEPTH_W)-1];

  // The read samples mem before this edge's write lands, so it is read-first.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/abuf_acc.sv
// Accumulation buffer: per-lane saturating read-modify-write of MAC results, plus a host readout port.
// Latency: an accumulate is written 3 cycles after the request. A host read returns data 2 cycles after acceptance.
// Backpressure: accumulates are never stalled. A host read is refused (rd_rdy=0) in any cycle that carries an accumulate.
//   clk, rst                                   : clock, async active-low reset
//   abuf_addr/abuf_acc_en/abuf_acc_new/mac_res : accumulate request
//   rd_en/rd_addr -> rd_rdy                    : host read request and accept
//   rd_data/rd_vld                             : host read response
//   busy                                       : accumulate pipeline non-empty
module abuf_acc
  import global_param::*;
#(
  parameter int ADDR_W = 8,
  parameter int DW     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   abuf_addr,
  input  logic [BATCH-1:0]    abuf_acc_en,
  input  logic                abuf_acc_new,
  input  logic [BATCH*DW-1:0] mac_res,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_rdy,
  output logic [BATCH*DW-1:0] rd_data,
  output logic                rd_vld,
  output logic                busy
);

  localparam int WW = BATCH * DW;

  logic              acc_req;
  logic [ADDR_W-1:0] ram_raddr;
  logic [WW-1:0]     ram_q;

  // S0: registered request
  logic              s0_vld;
  logic [ADDR_W-1:0] s0_addr;
  logic [BATCH-1:0]  s0_en;
  logic              s0_new;
  logic [WW-1:0]     s0_mac;

  // S2: merged word being written this cycle
  logic              s2_vld;
  logic [ADDR_W-1:0] s2_addr;
  logic [WW-1:0]     s2_word;

  // Word written at the previous edge. The RAM read for the current S0
  // request was issued on that same edge, so it returned the stale word.
  logic              wp_vld;
  logic [ADDR_W-1:0] wp_addr;
  logic [WW-1:0]     wp_word;

  logic [WW-1:0]     base;
  logic [WW-1:0]     merged;
  logic              rd_p1;

  assign acc_req   = |abuf_acc_en;
  assign rd_rdy    = rst & rd_en & ~acc_req;
  assign ram_raddr = acc_req ? abuf_addr : rd_addr;
  assign busy      = s0_vld | s2_vld;

  // Signed add that clamps to the DW-bit range instead of wrapping.
  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    if (s[DW] != s[DW-1])
      sat_add = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      sat_add = s[DW-1:0];
  endfunction

  sdp_ram #(
    .DEPTH_W (ADDR_W),
    .DW      (WW)
  ) u_ram (
    .clk   (clk),
    .we    (s2_vld),
    .waddr (s2_addr),
    .wdata (s2_word),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_vld  <= 1'b0;
      s0_addr <= '0;
      s0_en   <= '0;
      s0_new  <= 1'b0;
      s0_mac  <= '0;
    end else begin
      s0_vld  <= acc_req;
      s0_addr <= abuf_addr;
      s0_en   <= abuf_acc_en;
      s0_new  <= abuf_acc_new;
      s0_mac  <= mac_res;
    end
  end

  // S1: pick the freshest copy of the word. The distance-1 forward wins over distance-2.
  always_comb begin
    base = ram_q;
    if (wp_vld && (wp_addr == s0_addr)) base = wp_word;
    if (s2_vld && (s2_addr == s0_addr)) base = s2_word;
    merged = base;
    for (int i = 0; i < BATCH; i++) begin
      if (s0_en[i])
        merged[i*DW +: DW] = sat_add(s0_new ? {DW{1'b0}} : base[i*DW +: DW], s0_mac[i*DW +: DW]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_vld  <= 1'b0;
      s2_addr <= '0;
      s2_word <= '0;
      wp_vld  <= 1'b0;
      wp_addr <= '0;
      wp_word <= '0;
    end else begin
      s2_vld  <= s0_vld;
      s2_addr <= s0_addr;
      s2_word <= merged;
      wp_vld  <= s2_vld;
      wp_addr <= s2_addr;
      wp_word <= s2_word;
    end
  end

  // Host readout: RAM read on the accept edge, then capture on the next edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_p1   <= 1'b0;
      rd_vld  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_p1  <= rd_rdy;
      rd_vld <= rd_p1;
      if (rd_p1) rd_data <= ram_q;
    end
  end

endmodule
